// File: rtl/cmp_defs.sv
// Shared constants for the multi-channel comparator: compare-mode encodings
// and output FSM state codes.
package cmp_defs;

  // Compare modes, sampled together with the data word.
  localparam logic [1:0] MODE_ALL_EQ = 2'b00;  // every channel equal
  localparam logic [1:0] MODE_ANY_EQ = 2'b01;  // at least one equal pair
  localparam logic [1:0] MODE_MAJ    = 2'b10;  // strict majority equal to ch0
  localparam logic [1:0] MODE_ASC    = 2'b11;  // strictly ascending, unsigned

  // Output holding register states.
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  // Legal channel count range.
  localparam int CH_MIN = 2;
  localparam int CH_MAX = 8;

endpackage

// File: rtl/cmp_core.sv
// Combinational per-mode compare across CH channels of W bits each.
// Channel k lives at data[k*W +: W].
module cmp_core
  import cmp_defs::*;
#(
  parameter int W  = 8,
  parameter int CH = 3
) (
  input  logic [CH*W-1:0] data,
  input  logic [1:0]      mode,
  output logic            match
);

  // Packed view of the channels; layout is identical to the flat bus.
  logic [CH-1:0][W-1:0] ch;
  logic [CH-1:0]        eq0;     // channel k equals channel 0
  logic [CH-1:1]        asc_ok;  // channel k strictly above channel k-1
  logic                 any_eq;
  logic                 maj;
  logic [3:0]           eq_cnt;

  assign ch = data;

  genvar k;
  generate
    for (k = 0; k < CH; k++) begin : g_eq0
      assign eq0[k] = (ch[k] == ch[0]);
    end
    for (k = 1; k < CH; k++) begin : g_asc
      assign asc_ok[k] = (ch[k] > ch[k-1]);
    end
  endgenerate

  // Any pair i<j with equal values.
  always_comb begin
    any_eq = 1'b0;
    for (int i = 0; i < CH; i++) begin
      for (int j = i + 1; j < CH; j++) begin
        if (ch[i] == ch[j]) any_eq = 1'b1;
      end
    end
  end

  // Majority: channels equal to ch0 (ch0 itself included) exceed CH/2.
  always_comb begin
    eq_cnt = '0;
    for (int i = 0; i < CH; i++) begin
      eq_cnt = eq_cnt + 4'(eq0[i]);
    end
    maj = (eq_cnt > 4'(CH / 2));
  end

  // Select the result for the requested mode.
  always_comb begin
    match = 1'b0;
    case (mode)
      MODE_ALL_EQ: match = &eq0;
      MODE_ANY_EQ: match = any_eq;
      MODE_MAJ:    match = maj;
      MODE_ASC:    match = &asc_ok;
      default:     match = 1'b0;
    endcase
  end

endmodule

// File: rtl/multi_compare.sv
// Multi-channel comparator with a one-deep valid/ready output register and a
// saturating consecutive-match streak counter.
module multi_compare
  import cmp_defs::*;
#(
  parameter int W     = 8,
  parameter int CH    = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CH*W-1:0]  data,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] thresh,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             streak_hit
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [0:0] state;
  logic       wake_q;     // high during reset and for the first cycle after it
  logic       core_match;
  logic       accept;
  logic       can_take;

  cmp_core #(.W(W), .CH(CH)) u_core (
    .data  (data),
    .mode  (mode),
    .match (core_match)
  );

  // The register can take a beat when empty or when its content leaves now.
  assign can_take  = (state == ST_EMPTY) | out_ready;
  // Ready is forced high in reset; the post-reset guard cycle drops it.
  assign in_ready  = rst | (~wake_q & can_take);
  assign accept    = in_valid & can_take & ~rst & ~wake_q;
  assign out_valid = (state == ST_FULL);
  assign streak_hit = out_valid & (|thresh) & (match_cnt >= thresh);

  // Guard flag: keeps the first edge after reset release from accepting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wake_q <= 1'b1;
    else     wake_q <= 1'b0;
  end

  // Output FSM, result register and saturating streak counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_EMPTY;
      match     <= 1'b0;
      match_cnt <= '0;
    end else if (accept) begin
      state <= ST_FULL;
      match <= core_match;
      if (!core_match)                match_cnt <= '0;
      else if (match_cnt != CNT_MAX)  match_cnt <= match_cnt + 1'b1;
    end else if ((state == ST_FULL) && out_ready) begin
      state <= ST_EMPTY;
    end
  end

endmodule

// File: doc/multi_compare.md
MULTI_COMPARE -- requirements
Module: multi_compare

Interface
REQ-001 SHALL have parameter W, default 8: bits per channel word.
REQ-002 SHALL have parameter CH, default 3: channel count, legal range 2..8.
REQ-003 SHALL have parameter CNT_W, default 8: streak counter width.
REQ-004 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port in_valid, input, 1 bit: data/mode valid.
REQ-007 SHALL have port in_ready, output, 1 bit: block accepts this cycle.
REQ-008 SHALL have port data, input, CH*W bits: channel k at bits [k*W +: W].
REQ-009 SHALL have port mode, input, 2 bits: compare mode, sampled with data.
REQ-010 SHALL have port thresh, input, CNT_W bits: streak threshold, sampled continuously.
REQ-011 SHALL have port out_valid, output, 1 bit: result held.
REQ-012 SHALL have port out_ready, input, 1 bit: consumer takes result.
REQ-013 SHALL have port match, output, 1 bit: compare result.
REQ-014 SHALL have port match_cnt, output, CNT_W bits: consecutive-match streak.
REQ-015 SHALL have port streak_hit, output, 1 bit: streak at or above threshold.

Function
REQ-016 SHALL implement a two-state output FSM: EMPTY, where out_valid=0, and FULL, where out_valid=1.
REQ-017 SHALL drive in_ready = (state==EMPTY) | out_ready, combinationally.
REQ-018 SHALL treat a beat as accepted when in_valid & in_ready: result registered, state FULL next cycle (latency 1).
REQ-019 SHALL, in FULL, go to EMPTY on out_ready & !in_valid, and stay FULL with new result on out_ready & in_valid (back-to-back, one beat per cycle).
REQ-020 SHALL hold match, match_cnt and out_valid stable while FULL & !out_ready.
REQ-021 SHALL compute match for mode 00 (ALL_EQ): all CH channels equal.
REQ-022 SHALL compute match for mode 01 (ANY_EQ): at least one pair i<j with ch[i]==ch[j].
REQ-023 SHALL compute match for mode 10 (MAJ): count of channels equal to ch0, ch0 included, > CH/2 (integer division).
REQ-024 SHALL compute match for mode 11 (ASC): ch0<ch1<...<ch[CH-1], unsigned, strict.
REQ-025 SHALL, on each accepted beat, set the streak counter to match_cnt+1 on match, saturating at 2^CNT_W-1 with no wrap, and to 0 on mismatch.
REQ-026 SHALL update match_cnt only on accepted beats; beats not accepted and idle cycles leave it unchanged.
REQ-027 SHALL drive streak_hit = out_valid & (thresh!=0) & (match_cnt >= thresh), combinationally; thresh=0 never hits.
REQ-028 SHALL leave the streak unchanged when a mode change occurs between beats; mode only affects that beat's match.

Reset
REQ-029 SHALL, on rst high at any time including mid-stream, immediately force state EMPTY, out_valid=0, match=0, match_cnt=0, streak_hit=0.
REQ-030 SHALL hold in_ready=1 while rst is high, with no beat accepted.
REQ-031 SHALL not accept a beat on the first clk edge after rst deasserts.

Structure
REQ-032 SHALL define mode encodings MODE_ALL_EQ, MODE_ANY_EQ, MODE_MAJ and MODE_ASC as constants in a shared include/package, cmp_defs.
REQ-033 SHALL place the combinational per-mode compare in sub-module cmp_core (data, mode -> match), with the FSM and counter in multi_compare.

Verification
REQ-034 SHALL cover: rst pulse mid-stream with out_valid=1, match_cnt=5 -> all outputs 0 immediately, first accept after release yields match_cnt=1 on match.
REQ-035 SHALL cover (CH=3, W=8, mode ALL_EQ): {0,0,0} then {1,1,1} then {1,0,0} -> match 1,1,0, match_cnt 1,2,0.
REQ-036 SHALL cover: mode ANY_EQ {3,7,3} -> 1; MAJ {5,5,9} -> 1; MAJ {5,9,9} -> 0; ASC {1,2,3} -> 1; ASC {1,1,3} -> 0.
REQ-037 SHALL cover backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs frozen, no counter change; out_ready=1 -> next beat accepted in same cycle.
REQ-038 SHALL cover thresh=3, matching stream -> streak_hit rises exactly when match_cnt=3; thresh=0 -> never.
REQ-039 SHALL cover CNT_W=2 with 5 consecutive matches -> match_cnt 1,2,3,3,3, with no wrap.
